oldland_tlb_refill: RTL and testbench

Hardware page-table walker that fills the TLB entries on a miss. It takes a missing virtual page number and walks a two-level page table in memory through a single-outstanding read port. It then drives the per-entry load interface (virt/phys/access/load) of the selected victim entry. It sits between the MMU miss logic and the data-side memory arbiter, and reports completion or a translation fault.

---
 rtl/oldland_tlb_refill.sv | 245 ++++++++++++++++++++++++
 tb/tb_oldland_tlb_refill.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/oldland_tlb_refill.sv
// -----------------------------------------------------------------------------
// oldland_tlb_refill
//
// Hardware page-table walker. On a TLB miss it walks a two-level page table
// through a single-outstanding read port. It then either loads the victim TLB
// entry or reports a translation fault. The victim pointer is round-robin over
// ENTRIES entries.
//
// Descriptor format (PDE and PTE):
//   [31:12] base / frame, [4] present, [3:0] access (used from the PTE only)
//
// Ports:
//   clk, rst           core clock, synchronous active-high reset
//   ptbase_wr/_in      write the page-directory base ([31:12])
//   miss_req/_virt     start a walk for virtual page miss_virt (only when idle)
//   inval              invalidate-all: abort any walk, victim pointer back to 0
//   mem_addr/_rd       word address and read request, held until mem_ack
//   mem_ack/_data      read completion and read data
//   tlb_virt/_phys     virtual page / physical frame for the entry load
//   tlb_access         {user[1:0], supervisor[1:0]} access bits
//   tlb_load_sel       one-hot entry load strobe (one cycle)
//   busy               walk in progress (any state but IDLE)
//   miss_done          one-cycle pulse, entry loaded
//   miss_fault         one-cycle pulse, non-present PDE or PTE
//
// All outputs are registered. They are computed from the next state, so every
// output lines up with the state it belongs to. With zero-wait memory, a miss
// accepted at cycle N gives DIR_RD at N+1, TBL_RD at N+2 and LOAD at N+3.
// -----------------------------------------------------------------------------
module oldland_tlb_refill #(
  parameter int ENTRIES = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ptbase_wr,
  input  logic [19:0]        ptbase_in,
  input  logic               miss_req,
  input  logic [19:0]        miss_virt,
  input  logic               inval,
  output logic [31:0]        mem_addr,
  output logic               mem_rd,
  input  logic               mem_ack,
  input  logic [31:0]        mem_data,
  output logic [19:0]        tlb_virt,
  output logic [19:0]        tlb_phys,
  output logic [3:0]         tlb_access,
  output logic [ENTRIES-1:0] tlb_load_sel,
  output logic               busy,
  output logic               miss_done,
  output logic               miss_fault
);

  localparam int VW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DIR_RD = 3'd1,
    ST_TBL_RD = 3'd2,
    ST_LOAD   = 3'd3,
    ST_FAULT  = 3'd4
  } state_t;

  // Descriptor field helpers.
  function automatic logic desc_present(input logic [31:0] desc);
    return desc[4];
  endfunction

  function automatic logic [19:0] desc_base(input logic [31:0] desc);
    return desc[31:12];
  endfunction

  // One-hot strobe for the selected victim entry.
  function automatic logic [ENTRIES-1:0] onehot(input logic [VW-1:0] idx);
    logic [ENTRIES-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Round-robin successor, wrapping ENTRIES-1 back to 0.
  function automatic logic [VW-1:0] victim_next(input logic [VW-1:0] idx);
    if (idx == VW'(ENTRIES - 1)) begin
      return '0;
    end else begin
      return idx + VW'(1);
    end
  endfunction

  state_t              state_q, state_d;
  logic [19:0]         ptbase_q, ptbase_d;        // programmable directory base
  logic [19:0]         walk_base_q, walk_base_d;  // base captured at acceptance
  logic [19:0]         vpn_q, vpn_d;
  logic [19:0]         pde_q, pde_d;              // second-level table base
  logic [VW-1:0]       victim_q, victim_d;

  logic [31:0]         mem_addr_q, mem_addr_d;
  logic                mem_rd_q, mem_rd_d;
  logic [19:0]         tlb_virt_q, tlb_virt_d;
  logic [19:0]         tlb_phys_q, tlb_phys_d;
  logic [3:0]          tlb_access_q, tlb_access_d;
  logic [ENTRIES-1:0]  tlb_load_sel_q, tlb_load_sel_d;
  logic                busy_q, busy_d;
  logic                miss_done_q, miss_done_d;
  logic                miss_fault_q, miss_fault_d;

  // Descriptor bits [11:5] carry nothing the walker needs.
  logic                mem_data_unused;
  assign mem_data_unused = ^mem_data[11:5];

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d        = state_q;
    ptbase_d       = ptbase_wr ? ptbase_in : ptbase_q;
    walk_base_d    = walk_base_q;
    vpn_d          = vpn_q;
    pde_d          = pde_q;
    victim_d       = victim_q;
    tlb_virt_d     = tlb_virt_q;
    tlb_phys_d     = tlb_phys_q;
    tlb_access_d   = tlb_access_q;

    if (inval) begin
      // Invalidate wins over miss_req and mem_ack: drop the walk silently.
      state_d  = ST_IDLE;
      victim_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (miss_req) begin
            // ptbase_d already includes a same-cycle base write.
            walk_base_d = ptbase_d;
            vpn_d       = miss_virt;
            state_d     = ST_DIR_RD;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_DIR_RD: begin
          if (mem_ack) begin
            pde_d = desc_base(mem_data);
            if (desc_present(mem_data)) begin
              state_d = ST_TBL_RD;
            end else begin
              state_d = ST_FAULT;
            end
          end else begin
            state_d = ST_DIR_RD;
          end
        end
        ST_TBL_RD: begin
          if (mem_ack) begin
            if (desc_present(mem_data)) begin
              state_d      = ST_LOAD;
              tlb_virt_d   = vpn_q;
              tlb_phys_d   = desc_base(mem_data);
              tlb_access_d = mem_data[3:0];
            end else begin
              state_d = ST_FAULT;
            end
          end else begin
            state_d = ST_TBL_RD;
          end
        end
        ST_LOAD: begin
          victim_d = victim_next(victim_q);
          state_d  = ST_IDLE;
        end
        ST_FAULT: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    // Outputs follow the state being entered, so they are valid in that state.
    mem_rd_d     = (state_d == ST_DIR_RD) || (state_d == ST_TBL_RD);
    busy_d       = (state_d != ST_IDLE);
    miss_done_d  = (state_d == ST_LOAD);
    miss_fault_d = (state_d == ST_FAULT);
    if (state_d == ST_LOAD) begin
      // victim_q advances only on leaving LOAD, so this is the current victim.
      tlb_load_sel_d = onehot(victim_q);
    end else begin
      tlb_load_sel_d = '0;
    end

    // Read addresses are derived only from latched walk state, so they stay
    // stable for as long as the read is outstanding.
    case (state_d)
      ST_DIR_RD: mem_addr_d = {walk_base_d, vpn_d[19:10], 2'b00};
      ST_TBL_RD: mem_addr_d = {pde_d, vpn_d[9:0], 2'b00};
      default:   mem_addr_d = mem_addr_q;
    endcase
  end

  // Walker state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      ptbase_q       <= 20'h0;
      walk_base_q    <= 20'h0;
      vpn_q          <= 20'h0;
      pde_q          <= 20'h0;
      victim_q       <= '0;
      mem_addr_q     <= 32'h0;
      mem_rd_q       <= 1'b0;
      tlb_virt_q     <= 20'h0;
      tlb_phys_q     <= 20'h0;
      tlb_access_q   <= 4'h0;
      tlb_load_sel_q <= '0;
      busy_q         <= 1'b0;
      miss_done_q    <= 1'b0;
      miss_fault_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      ptbase_q       <= ptbase_d;
      walk_base_q    <= walk_base_d;
      vpn_q          <= vpn_d;
      pde_q          <= pde_d;
      victim_q       <= victim_d;
      mem_addr_q     <= mem_addr_d;
      mem_rd_q       <= mem_rd_d;
      tlb_virt_q     <= tlb_virt_d;
      tlb_phys_q     <= tlb_phys_d;
      tlb_access_q   <= tlb_access_d;
      tlb_load_sel_q <= tlb_load_sel_d;
      busy_q         <= busy_d;
      miss_done_q    <= miss_done_d;
      miss_fault_q   <= miss_fault_d;
    end
  end

  assign mem_addr     = mem_addr_q;
  assign mem_rd       = mem_rd_q;
  assign tlb_virt     = tlb_virt_q;
  assign tlb_phys     = tlb_phys_q;
  assign tlb_access   = tlb_access_q;
  assign tlb_load_sel = tlb_load_sel_q;
  assign busy         = busy_q;
  assign miss_done    = miss_done_q;
  assign miss_fault   = miss_fault_q;

endmodule

// File: tb/tb_oldland_tlb_refill.sv
// Scoreboard bench for oldland_tlb_refill: stimulus pushes expected results
// (from a page-table reference model) and expected read addresses; a memory
// responder and an output monitor check them independently.
module tb_oldland_tlb_refill;
  localparam int ENTRIES = 8;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               ptbase_wr = 1'b0;
  logic [19:0]        ptbase_in = 20'h0;
  logic               miss_req = 1'b0;
  logic [19:0]        miss_virt = 20'h0;
  logic               inval = 1'b0;
  logic [31:0]        mem_addr;
  logic               mem_rd;
  logic               mem_ack = 1'b0;
  logic [31:0]        mem_data = 32'h0;
  logic [19:0]        tlb_virt;
  logic [19:0]        tlb_phys;
  logic [3:0]         tlb_access;
  logic [ENTRIES-1:0] tlb_load_sel;
  logic               busy;
  logic               miss_done;
  logic               miss_fault;

  oldland_tlb_refill #(.ENTRIES(ENTRIES)) dut (
    .clk(clk), .rst(rst), .ptbase_wr(ptbase_wr), .ptbase_in(ptbase_in),
    .miss_req(miss_req), .miss_virt(miss_virt), .inval(inval),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_ack(mem_ack), .mem_data(mem_data),
    .tlb_virt(tlb_virt), .tlb_phys(tlb_phys), .tlb_access(tlb_access),
    .tlb_load_sel(tlb_load_sel), .busy(busy), .miss_done(miss_done),
    .miss_fault(miss_fault)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit                 fault;
    logic [ENTRIES-1:0] sel;
    logic [19:0]        virt;
    logic [19:0]        phys;
    logic [3:0]         acc;
    int                 cyc;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] addr_q[$];
  logic [31:0] mem [logic [31:0]];
  int          n_checks = 0;
  int          n_errors = 0;
  int          ack_delay = 0;
  logic [19:0] m_ptbase = 20'h0;
  int          m_victim = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_mem_rd"}, 32'(mem_rd), 32'h0);
    chk({tag, "_mem_addr"}, mem_addr, 32'h0);
    chk({tag, "_load_sel"}, 32'(tlb_load_sel), 32'h0);
    chk({tag, "_tlb_virt"}, 32'(tlb_virt), 32'h0);
    chk({tag, "_tlb_phys"}, 32'(tlb_phys), 32'h0);
    chk({tag, "_tlb_access"}, 32'(tlb_access), 32'h0);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
    chk({tag, "_miss_done"}, 32'(miss_done), 32'h0);
    chk({tag, "_miss_fault"}, 32'(miss_fault), 32'h0);
  endtask

  // Memory responder: acks after ack_delay wait cycles, checks addresses.
  initial begin : responder
    bit          pending;
    int          cnt;
    logic [31:0] hold;
    pending = 1'b0;
    cnt     = 0;
    hold    = 32'h0;
    forever begin
      @(posedge clk); #1;
      mem_ack = 1'b0;
      if (!mem_rd) begin
        pending = 1'b0;
        if ($urandom_range(3) == 0) begin
          mem_ack  = 1'b1;                 // stray ack, must be ignored
          mem_data = $urandom;
        end
      end else begin
        if (!pending) begin
          pending = 1'b1;
          cnt     = ack_delay;
          hold    = mem_addr;
          if (addr_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_read: mem_addr=0x%0h with no read expected (cycle %0d)", mem_addr, cyc);
          end else begin
            chk("mem_addr", mem_addr, addr_q.pop_front());
          end
        end else begin
          chk("mem_addr_stable", mem_addr, hold);
        end
        if (cnt == 0) begin
          mem_ack  = 1'b1;
          mem_data = mem.exists(hold) ? mem[hold] : 32'h0;
          pending  = 1'b0;
        end else begin
          cnt--;
        end
      end
    end
  end

  // Output monitor: pops the scoreboard on every done/fault pulse.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (tlb_load_sel != '0 && !miss_done) begin
        n_checks++;
        n_errors++;
        $display("FAIL stray_load_sel: tlb_load_sel=0x%0h without miss_done (cycle %0d)", tlb_load_sel, cyc);
      end
      if (miss_done || miss_fault) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_pulse: done=%0b fault=%0b with nothing outstanding (cycle %0d)", miss_done, miss_fault, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("miss_fault", 32'(miss_fault), 32'(e.fault));
          chk("miss_done", 32'(miss_done), 32'(!e.fault));
          chk("pulse_cycle", 32'(cyc), 32'(e.cyc));
          if (!e.fault) begin
            chk("tlb_load_sel", 32'(tlb_load_sel), 32'(e.sel));
            chk("tlb_virt", 32'(tlb_virt), 32'(e.virt));
            chk("tlb_phys", 32'(tlb_phys), 32'(e.phys));
            chk("tlb_access", 32'(tlb_access), 32'(e.acc));
          end else begin
            chk("fault_no_load", 32'(tlb_load_sel), 32'h0);
          end
        end
      end
    end
  end

  // Build a PDE/PTE pair for (base, vpn); tables live above 0x80000000.
  task automatic make_entries(input logic [19:0] base, input logic [19:0] vpn,
                              input bit pde_p, input bit pte_p);
    logic [31:0] pa, pta, pde, pte;
    pa      = {base, vpn[19:10], 2'b00};
    pde     = $urandom;
    pde[31] = 1'b1;
    pde[4]  = pde_p;
    mem[pa] = pde;
    pta     = {pde[31:12], vpn[9:0], 2'b00};
    pte     = $urandom;
    pte[4]  = pte_p;
    mem[pta] = pte;
  endtask

  task automatic set_base(input logic [19:0] b);
    ptbase_wr = 1'b1;
    ptbase_in = b;
    m_ptbase  = b;
    @(posedge clk); #1;
    ptbase_wr = 1'b0;
  endtask

  task automatic pulse_inval();
    inval = 1'b1;
    @(posedge clk); #1;
    inval    = 1'b0;
    m_victim = 0;
  endtask

  // One walk. abort: 0 none, 1 inval in TBL_RD at N+6, 2 rst in DIR_RD at N+2.
  task automatic walk(input logic [19:0] vpn, input bit wr_base, input logic [19:0] new_base,
                      input int d, input bit noise, input int abort);
    exp_t        e;
    logic [31:0] pa, pta, pde, pte;
    int          n;
    bit          fin;
    if (wr_base) m_ptbase = new_base;
    n       = cyc;
    e.fault = 1'b0;
    e.sel   = '0;
    e.virt  = 20'h0;
    e.phys  = 20'h0;
    e.acc   = 4'h0;
    pa  = {m_ptbase, vpn[19:10], 2'b00};
    pde = mem.exists(pa) ? mem[pa] : 32'h0;
    addr_q.push_back(pa);
    if (!pde[4]) begin
      e.fault = 1'b1;
      e.cyc   = n + 2 + d;
    end else begin
      pta = {pde[31:12], vpn[9:0], 2'b00};
      pte = mem.exists(pta) ? mem[pta] : 32'h0;
      addr_q.push_back(pta);
      e.cyc = n + 3 + 2 * d;
      if (!pte[4]) begin
        e.fault = 1'b1;
      end else begin
        e.sel  = ENTRIES'(1) << m_victim;
        e.virt = vpn;
        e.phys = pte[31:12];
        e.acc  = pte[3:0];
        if (abort == 0) m_victim = (m_victim + 1) % ENTRIES;
      end
    end
    if (abort == 0) exp_q.push_back(e);
    ack_delay = d;
    miss_req  = 1'b1;
    miss_virt = vpn;
    ptbase_wr = wr_base;
    ptbase_in = new_base;
    fin = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk); #1;
      miss_req  = 1'b0;
      ptbase_wr = 1'b0;
      inval     = 1'b0;
      rst       = 1'b0;
      if (abort == 1 && cyc == n + 7) begin
        chk("inval_mem_rd", 32'(mem_rd), 32'h0);
        chk("inval_busy", 32'(busy), 32'h0);
      end
      if (abort == 2 && cyc == n + 3) check_zero("midwalk_rst");
      if (!busy) begin
        fin = 1'b1;
        break;
      end
      if (abort == 1 && cyc == n + 6) begin
        inval = 1'b1;
      end else if (abort == 2 && cyc == n + 2) begin
        rst = 1'b1;
      end else if (noise) begin
        if ($urandom_range(1) == 0) begin
          miss_req  = 1'b1;                // ignored while busy
          miss_virt = 20'($urandom);
        end
        if ($urandom_range(3) == 0) begin
          ptbase_wr = 1'b1;                // must not affect this walk
          ptbase_in = 20'($urandom_range(20'h7FFFF));
          m_ptbase  = ptbase_in;
        end
      end
    end
    if (!fin) begin
      n_checks++;
      n_errors++;
      $display("FAIL walk_timeout: busy still high 200 cycles after miss at cycle %0d", n);
    end
    if (abort != 0) begin
      m_victim = 0;
      if (abort == 2) m_ptbase = 20'h0;
      addr_q.delete();
    end
  endtask

  task automatic random_walk(input int d, input bit noise);
    logic [19:0] vpn, nb;
    bit          wr;
    vpn = 20'($urandom);
    wr  = ($urandom_range(2) == 0);
    nb  = 20'($urandom_range(20'h7FFFF));
    make_entries(wr ? nb : m_ptbase, vpn, $urandom_range(7) != 0, $urandom_range(7) != 0);
    walk(vpn, wr, nb, d, noise, 0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    logic [19:0] v;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;

    // Directed walk with the documented table contents, zero-wait memory.
    set_base(20'h00010);
    mem[32'h0001_0400] = 32'h0002_0010;
    mem[32'h0002_048C] = 32'h1234_5016;
    walk(20'h40123, 1'b0, 20'h0, 0, 1'b0, 0);
    chk("directed_phys_hold", 32'(tlb_phys), 32'h12345);
    chk("directed_access_hold", 32'(tlb_access), 32'h6);
    chk("directed_virt_hold", 32'(tlb_virt), 32'h40123);

    // Non-present PDE, then non-present PTE.
    v = 20'h00400;
    make_entries(m_ptbase, v, 1'b0, 1'b1);
    walk(v, 1'b0, 20'h0, 0, 1'b0, 0);
    v = 20'h00801;
    make_entries(m_ptbase, v, 1'b1, 1'b0);
    walk(v, 1'b0, 20'h0, 0, 1'b0, 0);

    // Five-cycle memory with ignored miss_req pulses during the walk.
    v = 20'h3ABCD;
    make_entries(m_ptbase, v, 1'b1, 1'b1);
    walk(v, 1'b0, 20'h0, 5, 1'b1, 0);

    // Victim pointer sweep across all entries and back to 0.
    pulse_inval();
    for (int i = 0; i < 9; i++) begin
      v = 20'($urandom);
      make_entries(m_ptbase, v, 1'b1, 1'b1);
      walk(v, 1'b0, 20'h0, 0, 1'b0, 0);
    end
    chk("victim_wrap_sel", 32'(tlb_load_sel), 32'h0);  // strobe has dropped
    chk("victim_wrap_last_done", 32'(miss_done), 32'h0);

    // Randomized walks.
    for (int i = 0; i < 40; i++) begin
      random_walk($urandom_range(3), $urandom_range(1) == 1);
    end

    // Three walks, invalidate in TBL_RD, next walk loads entry 0.
    for (int i = 0; i < 3; i++) begin
      v = 20'($urandom);
      make_entries(m_ptbase, v, 1'b1, 1'b1);
      walk(v, 1'b0, 20'h0, 0, 1'b0, 0);
    end
    v = 20'($urandom);
    make_entries(m_ptbase, v, 1'b1, 1'b1);
    walk(v, 1'b0, 20'h0, 3, 1'b0, 1);
    v = 20'($urandom);
    make_entries(m_ptbase, v, 1'b1, 1'b1);
    walk(v, 1'b0, 20'h0, 0, 1'b0, 0);

    // Reset in DIR_RD; following walk uses base 0 and entry 0.
    walk(20'h0F0F0, 1'b0, 20'h0, 3, 1'b0, 2);
    v = 20'h12345;
    make_entries(20'h0, v, 1'b1, 1'b1);
    walk(v, 1'b0, 20'h0, 0, 1'b0, 0);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    chk("reads_drained", 32'(addr_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
